serial_detect_ctrl: RTL and testbench

SERIAL_DETECT_CTRL -- requirements
Module: serial_detect_ctrl

---
 rtl/serial_detect_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_detect_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_detect_ctrl.sv
// serial_detect_ctrl: serialises a 16-bit word into an external "10101"
// Moore detector and counts the matches reported back over the word.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   in_valid/in_ready    upstream word handshake, in_data[15:0]
//   det_rstn             registered active-low clear to the detector
//   det_in               serial bit to the detector
//   det_out              detector Moore output (last 5 bits == 10101)
//   out_valid/out_ready  result handshake, match_cnt[4:0]
//
// Build option: define LSB_FIRST_EN to shift in_data[0] first
// (default shifts in_data[15] first).

module serial_detect_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        det_rstn,
    output logic        det_in,
    input  logic        det_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  match_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        det_rstn_q, det_rstn_d;

    logic [4:0]  cnt_inc;
    logic        cur_bit;
    logic [15:0] sr_shift;

`ifdef LSB_FIRST_EN
    assign cur_bit  = sr_q[0];
    assign sr_shift = {1'b0, sr_q[15:1]};
`else
    assign cur_bit  = sr_q[15];
    assign sr_shift = {sr_q[14:0], 1'b0};
`endif

    assign cnt_inc = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            det_rstn_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            det_rstn_q <= det_rstn_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_d      = cnt_q;
        // Low only while the next state is CLR, so the flop output is a
        // clean one-cycle pulse aligned with CLR.
        det_rstn_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d       = in_data;
                    cnt_d      = '0;
                    det_rstn_d = 1'b0;
                    state_d    = CLR;
                end
            end
            CLR: begin
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                // det_out lags one cycle: it reflects the previous bit.
                if (bit_cnt_q != 4'd0 && det_out) begin
                    cnt_d = cnt_inc;
                end
                sr_d      = sr_shift;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (det_out) begin
                    cnt_d = cnt_inc;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign det_in    = (state_q == SHIFT) && cur_bit;
    assign det_rstn  = det_rstn_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_serial_detect_ctrl.sv
// tb_serial_detect_ctrl: directed bench for serial_detect_ctrl with a
// behavioural "10101" Moore detector attached to the det_* pins.

module tb_serial_detect_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        det_rstn;
    logic        det_in;
    logic        det_out;
    logic        out_valid;
    logic [4:0]  match_cnt;

    int n_chk = 0;
    int n_fail = 0;

    serial_detect_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .det_rstn  (det_rstn),
        .det_in    (det_in),
        .det_out   (det_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    // External detector model: last five bits shifted in, cleared by det_rstn.
    logic [4:0] hist;
    always_ff @(posedge clk or negedge det_rstn) begin
        if (!det_rstn) hist <= '0;
        else           hist <= {hist[3:0], det_in};
    end
    assign det_out = (hist == 5'b10101);

    typedef struct {
        logic [15:0] data;
        logic [4:0]  exp_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Order in which the bits of d are expected on det_in.
    function automatic logic [15:0] drive_order(input logic [15:0] d);
        logic [15:0] r;
`ifdef LSB_FIRST_EN
        r = d;
`else
        for (int k = 0; k < 16; k++) r[k] = d[15-k];
`endif
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where
    // out_valid is first seen (lat = edges after the accept edge).
    task automatic send(input logic [15:0] d, output int lat,
                        output int lows, output int stray,
                        output logic [15:0] seq);
        lat = -1;
        lows = 0;
        stray = 0;
        seq = '0;
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data = d;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            if (!det_rstn) lows++;
            if (i >= 1 && i <= 16) seq[i-1] = det_in;
            else if (det_in) stray++;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    vec_t vec [8];

    initial begin
        int lat, lows, stray, hi, lo;
        logic [15:0] seq;
        int acc [2];
        int res [2];
        int nacc, nres, ov_idx;
        logic pend;

        vec[0] = '{16'hAAAA, 5'd6};
        vec[1] = '{16'h0000, 5'd0};
        vec[2] = '{16'h5555, 5'd6};
        vec[3] = '{16'h0055, 5'd2};
        vec[4] = '{16'h0015, 5'd1};
        vec[5] = '{16'hFFFF, 5'd0};
        vec[6] = '{16'hA800, 5'd1};
        vec[7] = '{16'h0AAA, 5'd4};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_det_in", det_in, 0);
        chk("rst_det_rstn", det_rstn, 1);

        // First accept on the first edge after release, then the table.
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            send(vec[v].data, lat, lows, stray, seq);
            chk($sformatf("latency_%h", vec[v].data), lat, 18);
            chk($sformatf("match_%h", vec[v].data), match_cnt,
                vec[v].exp_cnt);
            chk($sformatf("det_rstn_pulse_%h", vec[v].data), lows, 1);
            chk($sformatf("det_in_outside_%h", vec[v].data), stray, 0);
            chk($sformatf("bit_order_%h", vec[v].data), seq,
                drive_order(vec[v].data));
            @(negedge clk);
            chk($sformatf("idle_out_valid_%h", vec[v].data), out_valid, 0);
            chk($sformatf("idle_in_ready_%h", vec[v].data), in_ready, 1);
        end

        // Single-bit word: det_in high in exactly one SHIFT cycle.
        send(16'h0001, lat, lows, stray, seq);
`ifdef LSB_FIRST_EN
        chk("one_hot_first", seq, 16'h0001);
`else
        chk("one_hot_last", seq, 16'h8000);
`endif
        chk("one_hot_match", match_cnt, 0);
        @(negedge clk);

        // Output stall with in_valid pressure.
        out_ready = 1'b0;
        send(16'h0015, lat, lows, stray, seq);
        chk("stall_latency", lat, 18);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data = 16'hFFFF;
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_match", match_cnt, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_idle", in_ready, 1);
        chk("stall_release_ov", out_valid, 0);
        chk("stall_no_accept", match_cnt, 1);

        // Reset in the middle of SHIFT (bit counter 7).
        in_valid = 1'b1;
        in_data = 16'hAAAA;
        @(posedge clk);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
        end
        rstn = 1'b0;
        #2;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_match", match_cnt, 0);
        chk("midrst_det_in", det_in, 0);
        chk("midrst_det_rstn", det_rstn, 1);
        @(negedge clk);
        rstn = 1'b1;
        hi = 0;
        lo = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) hi++;
            if (!in_ready) lo++;
        end
        chk("midrst_no_result", hi, 0);
        chk("midrst_stays_idle", lo, 0);
        send(16'h0055, lat, lows, stray, seq);
        chk("post_rst_latency", lat, 18);
        chk("post_rst_match", match_cnt, 2);
        @(negedge clk);

        // Back-to-back words with in_valid held high.
        nacc = 0;
        nres = 0;
        ov_idx = -1;
        pend = 1'b0;
        acc[0] = -1;
        acc[1] = -1;
        res[0] = -1;
        res[1] = -1;
        in_valid = 1'b1;
        in_data = 16'hA800;
        for (int t = 0; t < 60 && nres < 2; t++) begin
            if (pend) begin
                if (nacc == 1) in_data = 16'h0AAA;
                else in_valid = 1'b0;
                pend = 1'b0;
            end
            if (in_valid && in_ready && nacc < 2) begin
                acc[nacc] = t;
                nacc++;
                pend = 1'b1;
            end
            if (out_valid && nres < 2) begin
                if (nres == 0) ov_idx = t;
                res[nres] = match_cnt;
                nres++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_first_accept", acc[0], 0);
        chk("b2b_first_result_at", ov_idx, 19);
        chk("b2b_second_accept", acc[1], ov_idx + 1);
        chk("b2b_match0", res[0], 1);
        chk("b2b_match1", res[1], 4);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
